// File: rtl/vec_vsetvl_unit.sv
// Vector configuration-setting stage for vsetvli / vsetivli / vsetvl.
// It validates the requested vtype, computes vl = min(AVL, VLMAX), and writes the CSRs and rd.
module vec_vsetvl_unit #(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 64
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] cur_vl_i,
  output logic [XLEN-1:0] vtype_o,
  output logic [XLEN-1:0] vl_o,
  output logic            csrwr_en,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_e;

  localparam logic [XLEN-1:0] VLEN_X    = XLEN'(VLEN);
  localparam logic [XLEN-1:0] ELEN_X    = XLEN'(ELEN);
  localparam logic [XLEN-1:0] VILL_WORD = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   cur_vl_q, cur_vl_d;
  logic [XLEN-1:0]   vtype_q, vtype_d;
  logic [XLEN-1:0]   vl_q, vl_d;
  logic [4:0]        rd_addr_q, rd_addr_d;

  // Decode and vl computation on the captured instruction.
  logic [4:0]        rd_f, rs1_f;
  logic              is_vli, is_vili, is_vl, dec_valid;
  logic [XLEN-1:0]   req_vtype, avl, vlmax, new_vl, new_vtype;
  logic [2:0]        vsew, vlmul;
  logic              vill;

  always_comb begin
    rd_f    = inst_q[11:7];
    rs1_f   = inst_q[19:15];
    is_vli  = ~inst_q[31];
    is_vili = (inst_q[31:30] == 2'b11);
    is_vl   = (inst_q[31:25] == 7'b1000000);
    dec_valid = (inst_q[6:0] == 7'h57) && (inst_q[14:12] == 3'b111) &&
                (is_vli || is_vili || is_vl);

    if (is_vli)       req_vtype = XLEN'(inst_q[30:20]);
    else if (is_vili) req_vtype = XLEN'(inst_q[29:20]);
    else              req_vtype = rs2_q;

    // rs1=x0 with a live rd asks for VLMAX; with rd=x0 too it keeps the current vl.
    if (is_vili)          avl = XLEN'(rs1_f);
    else if (rs1_f != '0) avl = rs1_q;
    else if (rd_f != '0)  avl = '1;
    else                  avl = cur_vl_q;

    vsew  = req_vtype[5:3];
    vlmul = req_vtype[2:0];
    vill  = vlmul[2] || (vsew > 3'd3) || ((XLEN'(8) << vsew) > ELEN_X) ||
            (|req_vtype[XLEN-1:8]);

    vlmax = (VLEN_X >> (4'(vsew) + 4'd3)) << vlmul[1:0];

    if (vill) begin
      new_vl    = '0;
      new_vtype = VILL_WORD;
    end else begin
      new_vl    = (avl < vlmax) ? avl : vlmax;
      new_vtype = {{(XLEN-8){1'b0}}, req_vtype[7:0]};
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    inst_d    = inst_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cur_vl_d  = cur_vl_q;
    vtype_d   = vtype_q;
    vl_d      = vl_q;
    rd_addr_d = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          inst_d   = inst;
          rs1_d    = rs1_i;
          rs2_d    = rs2_i;
          cur_vl_d = cur_vl_i;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (dec_valid) begin
          vtype_d   = new_vtype;
          vl_d      = new_vl;
          rd_addr_d = rd_f;
          state_d   = WRITE;
        end else begin
          state_d   = IDLE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cur_vl_q  <= '0;
      vtype_q   <= VILL_WORD;
      vl_q      <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      cur_vl_q  <= cur_vl_d;
      vtype_q   <= vtype_d;
      vl_q      <= vl_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Strobes decode straight from state, so an async reset kills them at once.
  assign inst_ready = (state_q == IDLE);
  assign csrwr_en   = (state_q == WRITE);
  assign rd_we_o    = (state_q == WRITE);
  assign illegal_o  = (state_q == CALC) && !dec_valid;
  assign vtype_o    = vtype_q;
  assign vl_o       = vl_q;
  assign rd_wdata_o = vl_q;
  assign rd_addr_o  = rd_addr_q;

endmodule

// File: tb/tb_vec_vsetvl_unit.sv
// Scoreboard bench for vec_vsetvl_unit: expected CSR/rd writes are queued at issue time
// and compared by a monitor when the write or illegal strobe appears.
module tb_vec_vsetvl_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] VILL = 32'h8000_0000;

  typedef struct {
    logic        ill;
    logic [31:0] vtype;
    logic [31:0] vl;
    logic [4:0]  rd;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst, rs1_i, rs2_i, cur_vl_i;
  logic [31:0] vtype_o, vl_o, rd_wdata_o;
  logic        csrwr_en, rd_we_o, illegal_o;
  logic [4:0]  rd_addr_o;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  vec_vsetvl_unit #(.XLEN(XLEN), .VLEN(512), .ELEN(64)) dut (
    .clk(clk), .n_rst(n_rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .rs1_i(rs1_i), .rs2_i(rs2_i), .cur_vl_i(cur_vl_i),
    .vtype_o(vtype_o), .vl_o(vl_o), .csrwr_en(csrwr_en), .rd_addr_o(rd_addr_o),
    .rd_wdata_o(rd_wdata_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_vli(logic [4:0] rd, logic [4:0] rs1, logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] enc_vili(logic [4:0] rd, logic [4:0] uimm, logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] enc_vl(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  task automatic monitor();
    sb_item_t e;
    forever begin
      @(negedge clk);
      if (n_rst && (csrwr_en || illegal_o)) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_strobe: csrwr_en=%0b illegal_o=%0b with empty queue", csrwr_en, illegal_o);
        end else begin
          e = sb_q.pop_front();
          if (e.ill) begin
            if ({illegal_o, csrwr_en, rd_we_o} !== 3'b100) begin
              n_fail++;
              $display("FAIL sb_illegal: {illegal,csrwr,rd_we}=%b expected 100", {illegal_o, csrwr_en, rd_we_o});
            end
          end else begin
            if ({csrwr_en, rd_we_o, illegal_o} !== 3'b110) begin
              n_fail++;
              $display("FAIL sb_strobes: {csrwr,rd_we,illegal}=%b expected 110", {csrwr_en, rd_we_o, illegal_o});
            end
            n_checks++;
            if (vtype_o !== e.vtype) begin
              n_fail++;
              $display("FAIL sb_vtype: got 0x%08h expected 0x%08h", vtype_o, e.vtype);
            end
            n_checks++;
            if (vl_o !== e.vl || rd_wdata_o !== e.vl) begin
              n_fail++;
              $display("FAIL sb_vl: vl_o=%0d rd_wdata_o=%0d expected %0d", vl_o, rd_wdata_o, e.vl);
            end
            n_checks++;
            if (rd_addr_o !== e.rd) begin
              n_fail++;
              $display("FAIL sb_rd_addr: got %0d expected %0d", rd_addr_o, e.rd);
            end
          end
        end
      end
    end
  endtask

  // Issue one instruction, queue its expected result, and check handshake/strobe timing.
  task automatic issue(input logic [31:0] i_w, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] cv, input logic ill,
                       input logic [31:0] e_vtype, input logic [31:0] e_vl);
    sb_item_t it;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!inst_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!inst_ready) begin
      n_fail++;
      $display("FAIL issue_ready_timeout: inst_ready=%0b after %0d cycles", inst_ready, guard);
      return;
    end
    inst = i_w; rs1_i = r1; rs2_i = r2; cur_vl_i = cv; inst_valid = 1'b1;
    it.ill = ill; it.vtype = e_vtype; it.vl = e_vl; it.rd = i_w[11:7];
    sb_q.push_back(it);
    @(posedge clk);
    #1 inst_valid = 1'b0;
    inst = 32'hDEAD_BEEF; rs1_i = 32'h0; rs2_i = 32'hFFFF_FFFF; cur_vl_i = 32'h0;
    @(negedge clk);
    n_checks++;
    if (inst_ready !== 1'b0 || illegal_o !== ill || csrwr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_calc: ready=%0b illegal=%0b csrwr=%0b expected 0 %0b 0", inst_ready, illegal_o, csrwr_en, ill);
    end
    @(negedge clk);
    n_checks++;
    if (ill) begin
      if (inst_ready !== 1'b1 || illegal_o !== 1'b0 || csrwr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL t2_illegal_idle: ready=%0b illegal=%0b csrwr=%0b expected 1 0 0", inst_ready, illegal_o, csrwr_en);
      end
    end else begin
      if (inst_ready !== 1'b0 || csrwr_en !== 1'b1 || rd_we_o !== 1'b1) begin
        n_fail++;
        $display("FAIL t2_write: ready=%0b csrwr=%0b rd_we=%0b expected 0 1 1", inst_ready, csrwr_en, rd_we_o);
      end
      @(negedge clk);
      n_checks++;
      if (inst_ready !== 1'b1 || csrwr_en !== 1'b0 || rd_we_o !== 1'b0) begin
        n_fail++;
        $display("FAIL t3_idle: ready=%0b csrwr=%0b rd_we=%0b expected 1 0 0", inst_ready, csrwr_en, rd_we_o);
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({inst_ready, csrwr_en, rd_we_o, illegal_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_strobes: {ready,csrwr,rd_we,illegal}=%b expected 1000", {inst_ready, csrwr_en, rd_we_o, illegal_o});
    end
    n_checks++;
    if (vtype_o !== VILL || vl_o !== 0 || rd_wdata_o !== 0 || rd_addr_o !== 0) begin
      n_fail++;
      $display("FAIL reset_values: vtype=0x%08h vl=%0d wdata=%0d rd=%0d expected 0x80000000 0 0 0",
               vtype_o, vl_o, rd_wdata_o, rd_addr_o);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_vsetvli();
    issue(enc_vli(5'd1, 5'd5, 11'h011), 32'd100, 32'd0, 32'd0, 1'b0, 32'h11, 32'd32);
  endtask

  task automatic test_vsetivli();
    issue(enc_vili(5'd2, 5'd5, 10'h0C0), 32'd1000, 32'd0, 32'd0, 1'b0, 32'hC0, 32'd5);
    issue(enc_vli(5'd3, 5'd0, 11'h00A), 32'd7, 32'd0, 32'd0, 1'b0, 32'h0A, 32'd128);
  endtask

  task automatic test_avl_and_vill();
    issue(enc_vli(5'd0, 5'd0, 11'h01B), 32'd0, 32'd0, 32'd20, 1'b0, 32'h1B, 32'd20);
    issue(enc_vl(5'd4, 5'd6, 5'd7), 32'd10, 32'h20, 32'd0, 1'b0, VILL, 32'd0);
    // AVL exactly VLMAX (e64 m4 ta = 32) and unsigned-huge AVL (e8 m8 = 512).
    issue(enc_vl(5'd7, 5'd6, 5'd8), 32'd32, 32'h5A, 32'd0, 1'b0, 32'h5A, 32'd32);
    issue(enc_vli(5'd8, 5'd9, 11'h003), 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b0, 32'h03, 32'd512);
    issue(enc_vli(5'd9, 5'd9, 11'h100), 32'd4, 32'd0, 32'd0, 1'b0, VILL, 32'd0);
    issue(enc_vl(5'd10, 5'd6, 5'd8), 32'd4, 32'h05, 32'd0, 1'b0, VILL, 32'd0);
  endtask

  task automatic test_illegal();
    issue(32'h00B5_0533, 32'd1, 32'd2, 32'd3, 1'b1, 32'h0, 32'h0);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    inst = enc_vli(5'd11, 5'd5, 11'h011); rs1_i = 32'd9; inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({inst_ready, csrwr_en, rd_we_o, illegal_o} !== 4'b1000 || vtype_o !== VILL ||
        vl_o !== 0 || rd_addr_o !== 0) begin
      n_fail++;
      $display("FAIL abort_reset_values: ready=%0b csrwr=%0b vtype=0x%08h vl=%0d rd=%0d expected 1 0 0x80000000 0 0",
               inst_ready, csrwr_en, vtype_o, vl_o, rd_addr_o);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (csrwr_en !== 1'b0 || rd_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_write: csrwr=%0b rd_we=%0b expected 0 0", csrwr_en, rd_we_o);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    sb_item_t it;
    logic [8:0] ready_seen;
    ready_seen = '0;
    it.ill = 1'b0; it.vtype = 32'hC0; it.vl = 32'd5; it.rd = 5'd2;
    repeat (3) sb_q.push_back(it);
    @(negedge clk);
    inst = enc_vili(5'd2, 5'd5, 10'h0C0); rs1_i = 32'd0; inst_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      ready_seen[k] = inst_ready;
    end
    @(negedge clk);
    inst_valid = 1'b0;
    n_checks++;
    if (ready_seen !== 9'b001_001_001) begin
      n_fail++;
      $display("FAIL b2b_accept_spacing: ready pattern %b expected 001001001", ready_seen);
    end
  endtask

  initial begin
    inst_valid = 1'b0; inst = '0; rs1_i = '0; rs2_i = '0; cur_vl_i = '0; n_rst = 1'b0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_vsetvli();
    test_vsetivli();
    test_avl_and_vill();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected results never observed, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
